bit_deserializer: RTL and testbench
===================================

BIT_DESERIALIZER -- requirements
Module: bit_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per word (legal 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rstb, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port d, input, 1, serial data bit from the upstream flop stage.
REQ-005 SHALL have port d_valid, input, 1, d is sampled this cycle when high.
REQ-006 SHALL have port q_data, output, WIDTH, assembled word, registered.
REQ-007 SHALL have port q_valid, output, 1, q_data holds an unconsumed word.
REQ-008 SHALL have port q_ready, input, 1, downstream accepts q_data when high with q_valid.
REQ-009 SHALL have port overrun, output, 1, one-cycle pulse when a completed word is dropped.
REQ-010 SHALL have port par_err, output, 1, parity mismatch flag qualified by q_valid.

Function
REQ-011 SHALL shift d into the shift register LSB-first on each cycle with d_valid=1; d_valid=0 cycles SHALL leave the shift register and bit counter unchanged.
REQ-012 SHALL use a bit counter of width clog2(WIDTH+1) counting 0..N-1, where N=WIDTH (or WIDTH+1 with parity); it wraps to 0 on the Nth accepted bit.
REQ-013 SHALL implement FSM states IDLE (counter=0, no bits held), SHIFT (1..N-1 bits held); IDLE->SHIFT on first d_valid, SHIFT->IDLE on Nth bit.
REQ-014 SHALL complete a word on the cycle the Nth bit is sampled; q_data/q_valid SHALL update on the following edge (latency 1 clk from last bit to q_valid=1).
REQ-015 SHALL hold q_data stable and q_valid=1 until a cycle with q_valid=1 and q_ready=1; q_valid SHALL clear next edge unless a new word completes that same cycle.
REQ-016 SHALL, on completion while q_valid=1 and q_ready=1, load the new word and keep q_valid=1 with no bubble.
REQ-017 SHALL, on completion while q_valid=1 and q_ready=0, discard the new word, keep old q_data, and pulse overrun for exactly one cycle.
REQ-018 SHALL keep accepting serial bits regardless of q_valid (shift register and output register are independent buffers).
REQ-019 SHALL ignore q_ready when q_valid=0.

Reset
REQ-020 SHALL, on rstb=0, asynchronously force state=IDLE, counter=0, shift register=0, q_data=0, q_valid=0, overrun=0, par_err=0.
REQ-021 SHALL discard any partially assembled word when reset asserts mid-word; first d_valid after release is bit 0.
REQ-022 SHALL deassert reset synchronously with respect to internal use: no sampling on the edge coincident with rstb rising.

Configuration
REQ-023 SHALL compile parity support only when macro BIT_DESERIALIZER_PARITY_EN is defined.
REQ-024 SHALL, with BIT_DESERIALIZER_PARITY_EN, treat bit N=WIDTH+1 as even-parity bit; par_err registers (XOR of data bits ^ parity bit) alongside q_data and is cleared when the word is consumed.
REQ-025 SHALL, without BIT_DESERIALIZER_PARITY_EN, use N=WIDTH and drive par_err constant 0.

Structure
REQ-026 SHALL place FSM state encoding (IDLE=0, SHIFT=1) and default WIDTH constant in shared package bit_deserializer_pkg.
REQ-027 SHALL instantiate one sub-module deser_shift_reg (shift register plus bit counter, asserts done on Nth bit); output buffering and handshake stay in the top.

Verification
REQ-028 SHALL cover: WIDTH=8, bits 1,0,1,0,0,1,0,1 LSB-first with d_valid=1, q_ready=1 -> q_data=8'hA5, q_valid=1 for one cycle, 1 clk after last bit.
REQ-029 SHALL cover: same word with d_valid toggling 0/1 each cycle -> q_data=8'hA5, completion 16 cycles after start, no extra bits sampled.
REQ-030 SHALL cover: two back-to-back words 8'h3C, 8'hC3, q_ready=0 throughout -> q_data stays 8'h3C, overrun pulses once on second completion.
REQ-031 SHALL cover: completion coincident with q_ready=1 on held word 8'h11, new word 8'h22 -> q_valid stays 1, q_data becomes 8'h22 with no bubble.
REQ-032 SHALL cover: rstb pulsed low after 5 bits -> all outputs 0; next 8 bits 8'hFF -> q_data=8'hFF.
REQ-033 SHALL cover (BIT_DESERIALIZER_PARITY_EN): word 8'h01 with parity bit 0 -> par_err=1; with parity bit 1 -> par_err=0.

Source files
------------

// File: rtl/bit_deserializer_pkg.sv
// Shared constants and FSM encoding for the bit deserializer.
package bit_deserializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/deser_shift_reg.sv
// LSB-first shift register with bit counter; o_done is asserted combinationally
// during the cycle in which the Nth accepted bit is presented.
module deser_shift_reg
    import bit_deserializer_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_d,
    input  logic         i_d_valid,
    output logic         o_done,
    output logic [N-1:0] o_word
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [N-1:0]    r_shift;
    logic            w_done;

    // New bits enter at the MSB so the first bit ends up at bit 0.
    assign o_word = {i_d, r_shift[N-1:1]};
    assign o_done = w_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (i_d_valid) begin
                r_shift <= o_word;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        if (i_d_valid) begin
            if (r_cnt == CW'(N - 1)) begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
                w_done      = 1'b1;
            end else begin
                w_cnt_nxt   = r_cnt + CW'(1);
                w_state_nxt = SHIFT;
            end
        end
    end

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel deserializer with a one-word output buffer and valid/ready
// handshake. Define BIT_DESERIALIZER_PARITY_EN to add a trailing even-parity bit.
module bit_deserializer
    import bit_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q_data,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             overrun,
    output logic             par_err
);

`ifdef BIT_DESERIALIZER_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: a word transfers on any edge where q_valid and q_ready are both
    // high; q_ready is ignored while q_valid is low.

    logic             r_rst_meta;
    logic             r_rst_sync;
    logic             w_rst_n;
    logic             w_done;
    logic [N-1:0]     w_word;
    logic             w_load;
    logic             w_drop;
    logic             w_consume;
    logic [WIDTH-1:0] r_q_data;
    logic             r_q_valid;
    logic             r_overrun;

    // Reset asserts immediately but releases two edges later, so no bit is
    // sampled on the edge coincident with rstb rising.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst_n = r_rst_sync;

    deser_shift_reg #(
        .N  (N),
        .CW (CW)
    ) u_shift_reg (
        .i_clk     (clk),
        .i_rst_n   (w_rst_n),
        .i_d       (d),
        .i_d_valid (d_valid),
        .o_done    (w_done),
        .o_word    (w_word)
    );

    assign w_consume = r_q_valid & q_ready;
    assign w_load    = w_done & (~r_q_valid | q_ready);
    assign w_drop    = w_done & r_q_valid & ~q_ready;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_q_data  <= '0;
            r_q_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            if (w_load) begin
                r_q_data  <= w_word[WIDTH-1:0];
                r_q_valid <= 1'b1;
            end else if (w_consume) begin
                r_q_valid <= 1'b0;
            end
        end
    end

`ifdef BIT_DESERIALIZER_PARITY_EN
    logic r_par_err;

    // Even parity: XOR over data plus parity bit must be zero.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_par_err <= 1'b0;
        end else if (w_load) begin
            r_par_err <= ^w_word;
        end else if (w_consume) begin
            r_par_err <= 1'b0;
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

    assign q_data  = r_q_data;
    assign q_valid = r_q_valid;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed testbench for bit_deserializer with WIDTH=8.
module tb_bit_deserializer;

`ifdef BIT_DESERIALIZER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk;
    logic       rstb;
    logic       d;
    logic       d_valid;
    logic [7:0] q_data;
    logic       q_valid;
    logic       q_ready;
    logic       overrun;
    logic       par_err;

    int errors = 0;
    int checks = 0;

    bit_deserializer #(.WIDTH(8)) dut (
        .clk     (clk),
        .rstb    (rstb),
        .d       (d),
        .d_valid (d_valid),
        .q_data  (q_data),
        .q_valid (q_valid),
        .q_ready (q_ready),
        .overrun (overrun),
        .par_err (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_valid = 1'b0;
        tick();
    endtask

    // Frame with correct even parity appended when parity is compiled in.
    function automatic logic [8:0] frame(input logic [7:0] w);
        return {^w, w};
    endfunction

    task automatic send_bits(input logic [8:0] f, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            d       = f[i];
            d_valid = 1'b1;
            tick();
        end
        d_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstb = 1'b0; d = 1'b0; d_valid = 1'b0; q_ready = 1'b0;
        tick(); tick(); tick();
        checks++; if (q_data !== 8'h00) begin errors++; $display("FAIL reset_q_data: got %h expected 00", q_data); end
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_q_valid: got %b expected 0", q_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b expected 0", par_err); end
        rstb = 1'b1;
        idle(); idle(); idle();
    endtask

    task automatic test_basic();
        logic [8:0] f;
        f = frame(8'hA5);
        q_ready = 1'b1;
        send_bits(f, 0, NB - 1);
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", q_valid); end
        send_bits(f, NB - 1, NB);
        checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", q_valid); end
        checks++; if (q_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", q_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b expected 0", overrun); end
        idle();
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_clear: got %b expected 0", q_valid); end
    endtask

    task automatic test_valid_gaps();
        logic [8:0] f;
        f = frame(8'hA5);
        q_ready = 1'b1;
        for (int i = 0; i < NB; i++) begin
            d = ~f[i]; d_valid = 1'b0;
            tick();
            d = f[i];  d_valid = 1'b1;
            tick();
            if (i == NB - 2) begin
                checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL gaps_early_valid: got %b expected 0", q_valid); end
            end
        end
        d_valid = 1'b0;
        checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL gaps_valid: got %b expected 1", q_valid); end
        checks++; if (q_data !== 8'hA5) begin errors++; $display("FAIL gaps_data: got %h expected a5", q_data); end
        idle();
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL gaps_valid_clear: got %b expected 0", q_valid); end
    endtask

    task automatic test_overrun();
        q_ready = 1'b0;
        send_bits(frame(8'h3C), 0, NB);
        checks++; if (q_data !== 8'h3C) begin errors++; $display("FAIL ovr_first_data: got %h expected 3c", q_data); end
        send_bits(frame(8'hC3), 0, NB - 1);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b expected 0", overrun); end
        send_bits(frame(8'hC3), NB - 1, NB);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b expected 1", overrun); end
        checks++; if (q_data !== 8'h3C) begin errors++; $display("FAIL ovr_kept_data: got %h expected 3c", q_data); end
        checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", q_valid); end
        idle();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_one_cycle: got %b expected 0", overrun); end
        checks++; if (q_data !== 8'h3C) begin errors++; $display("FAIL ovr_held: got %h expected 3c", q_data); end
        q_ready = 1'b1;
        idle();
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL ovr_consumed: got %b expected 0", q_valid); end
    endtask

    task automatic test_back_to_back();
        q_ready = 1'b0;
        send_bits(frame(8'h11), 0, NB);
        checks++; if (q_data !== 8'h11) begin errors++; $display("FAIL b2b_first: got %h expected 11", q_data); end
        send_bits(frame(8'h22), 0, NB - 1);
        checks++; if (q_data !== 8'h11) begin errors++; $display("FAIL b2b_hold: got %h expected 11", q_data); end
        q_ready = 1'b1;
        send_bits(frame(8'h22), NB - 1, NB);
        checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble: got %b expected 1", q_valid); end
        checks++; if (q_data !== 8'h22) begin errors++; $display("FAIL b2b_data: got %h expected 22", q_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
        idle();
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL b2b_clear: got %b expected 0", q_valid); end
    endtask

    task automatic test_reset_mid_word();
        q_ready = 1'b0;
        send_bits(frame(8'h5A), 0, NB);
        send_bits(frame(8'hFF), 0, 5);
        #2;
        rstb = 1'b0;
        #1;
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", q_valid); end
        checks++; if (q_data !== 8'h00) begin errors++; $display("FAIL rst_async_data: got %h expected 00", q_data); end
        tick(); tick();
        rstb = 1'b1;
        idle(); idle(); idle();
        q_ready = 1'b1;
        send_bits(frame(8'hFF), 0, NB - 1);
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL rst_partial_discard: got %b expected 0", q_valid); end
        send_bits(frame(8'hFF), NB - 1, NB);
        checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL rst_after_valid: got %b expected 1", q_valid); end
        checks++; if (q_data !== 8'hFF) begin errors++; $display("FAIL rst_after_data: got %h expected ff", q_data); end
        idle();
    endtask

`ifdef BIT_DESERIALIZER_PARITY_EN
    task automatic test_parity();
        q_ready = 1'b1;
        send_bits({1'b0, 8'h01}, 0, 9);
        checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_bad: got %b expected 1", par_err); end
        checks++; if (q_data !== 8'h01) begin errors++; $display("FAIL par_bad_data: got %h expected 01", q_data); end
        idle();
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_clear: got %b expected 0", par_err); end
        send_bits({1'b1, 8'h01}, 0, 9);
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_good: got %b expected 0", par_err); end
        checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL par_good_valid: got %b expected 1", q_valid); end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_valid_gaps();
        test_overrun();
        test_back_to_back();
        test_reset_mid_word();
`ifdef BIT_DESERIALIZER_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
